inst_mem_loader: RTL
====================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 clock  input  1  single system clock; all state SHALL change on posedge clock only.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 length  input  ADDR_W+1  number of 32-bit words to load; sampled only in the cycle start is accepted.
REQ-006 byte_valid  input  1  host byte-stream valid.
REQ-007 byte_data  input  8  host byte-stream data.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  ADDR_W  word address of the current write; the core's PC indexes words.
REQ-011 mem_wdata  output  32  instruction word being written.
REQ-012 core_hold  output  1  high keeps the core's PC and register writes frozen.
REQ-013 busy  output  1  high while in LOAD.
REQ-014 done  output  1  high while in DONE.
REQ-015 error  output  1  high while in ERROR.
REQ-016 checksum  output  32  XOR of all words written in the current or last load.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE, ERROR, encoded as a registered state machine.
REQ-018 A byte SHALL transfer exactly in cycles where byte_valid and byte_ready are both high; byte_ready SHALL equal (state == LOAD).
REQ-019 Bytes SHALL be assembled big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-020 In the cycle after the 4th byte of a word transfers, mem_we SHALL be 1 for exactly one cycle, with mem_wdata = assembled word and mem_addr = word index (0 for the first word, incrementing by 1).
REQ-021 byte_ready SHALL stay high during a write cycle; back-to-back bytes SHALL sustain one word per 4 cycles with no stalls.
REQ-022 checksum SHALL update to checksum XOR mem_wdata in the same cycle mem_we is high.
REQ-023 IDLE/DONE/ERROR + start with 1 <= length <= 2^ADDR_W: go to LOAD next cycle; clear word index, byte counter, checksum; core_hold = 1.
REQ-024 IDLE/DONE/ERROR + start with length == 0 or length > 2^ADDR_W: go to ERROR; no memory write; core_hold = 1.
REQ-025 start while in LOAD SHALL be ignored.
REQ-026 The cycle after the write of word length-1: go to DONE; byte_ready = 0, core_hold = 0, done = 1.
REQ-027 Word index SHALL never wrap: the last legal address 2^ADDR_W-1 ends the load.
REQ-028 Bytes offered outside LOAD SHALL be neither accepted nor stored.
REQ-029 mem_we SHALL never be high outside the cycle defined in REQ-020.
REQ-030 core_hold SHALL be 0 only in DONE.

Reset
REQ-031 While reset_n = 0, state SHALL be IDLE and outputs SHALL be: byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_hold 1, busy 0, done 0, error 0, checksum 0.
REQ-032 Reset asserted mid-load SHALL discard any partial word immediately, with no write strobe; the core remains held until a new load completes.
REQ-033 After reset_n deasserts, the loader SHALL remain in IDLE until start.

Verification
REQ-034 Normal load: reset, start with length = 2, stream 8'h20,8'h08,8'h00,8'h05,8'h00,8'h00,8'h00,8'h08 back-to-back -> mem_we at addr 0 with 32'h20080005, then at addr 1 with 32'h00000008; checksum 32'h2008000D; done = 1; core_hold = 0.
REQ-035 Throttled stream: same data with byte_valid toggling every other cycle -> identical writes and checksum; no byte lost or duplicated.
REQ-036 Bad length: start with length = 0, then start with length = 2^ADDR_W+1 -> error = 1, no mem_we, core_hold = 1; a following start with length = 1 -> recovers to LOAD.
REQ-037 Full depth: length = 2^ADDR_W -> final write at addr 2^ADDR_W-1, then DONE; no write at addr 0 afterwards.
REQ-038 Reset mid-word: assert reset_n = 0 after 2 bytes of word 1 -> no mem_we, all outputs at reset values; a new load of length = 1 then writes addr 0 correctly.
REQ-039 Ignored inputs: start pulse during LOAD, and bytes offered in IDLE/DONE -> no effect on address, data, or checksum.

Source files
------------

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Streams a program into instruction memory from a host byte interface.
//   Every four bytes are packed big-endian into one 32-bit word and written
//   at consecutive word addresses starting from 0. The core is held frozen
//   until a load finishes.
//
// Parameters
//   ADDR_W      instruction-memory word-address width (depth 2**ADDR_W)
//
// Ports
//   clock       system clock; all state changes on its rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle request to begin a load (ignored while loading)
//   length      number of words to load, sampled with an accepted start
//   byte_valid  host byte valid
//   byte_data   host byte
//   byte_ready  loader accepts a byte this cycle (high only while loading)
//   mem_we      one-cycle instruction-memory write strobe
//   mem_addr    word address of the write
//   mem_wdata   word being written
//   core_hold   freezes the core; low only once a load has completed
//   busy        loading
//   done        load completed
//   error       last start carried an illegal length
//   checksum    XOR of every word written by the current or last load
module inst_mem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

   state_t            state;
   logic [1:0]        byte_cnt;
   logic [23:0]       shift_p0;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] last_idx;
   logic              last_sent;

   logic              len_ok;
   logic [ADDR_W:0]   len_m1;
   logic              xfer;
   logic [31:0]       word_full;

   // Legal lengths are 1 .. 2**ADDR_W: either the top bit is clear, or it is
   // set with all lower bits zero (exactly 2**ADDR_W).
   assign len_ok    = (length != '0) && (!length[ADDR_W] || (length[ADDR_W-1:0] == '0));
   assign len_m1    = length - {{ADDR_W{1'b0}}, 1'b1};

   // Once the final word has been captured, further bytes offered during the
   // closing write cycle are handshaken but dropped.
   assign xfer      = byte_valid && (state == LOAD) && !last_sent;
   assign word_full = {shift_p0, byte_data};

   assign byte_ready = (state == LOAD);
   assign busy       = (state == LOAD);
   assign done       = (state == DONE);
   assign error      = (state == ERROR);
   assign core_hold  = (state != DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         byte_cnt  <= 2'd0;
         shift_p0  <= '0;
         word_idx  <= '0;
         last_idx  <= '0;
         last_sent <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         checksum  <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  if (len_ok) begin
                     state     <= LOAD;
                     byte_cnt  <= 2'd0;
                     word_idx  <= '0;
                     last_idx  <= len_m1[ADDR_W-1:0];
                     last_sent <= 1'b0;
                     checksum  <= '0;
                  end else begin
                     state <= ERROR;
                  end
               end
            end
            LOAD: begin
               // Leave one cycle after the final word's write strobe.
               if (mem_we && last_sent)
                  state <= DONE;
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx;
                     mem_wdata <= word_full;
                     checksum  <= checksum ^ word_full;
                     // The index stops at the last word rather than wrapping.
                     if (word_idx == last_idx)
                        last_sent <= 1'b1;
                     else
                        word_idx <= word_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                  end else begin
                     shift_p0 <= {shift_p0[15:0], byte_data};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
